// File: rtl/video_timing_pkg.sv
// Shared timing constants, enums and output bit positions for the video timing generator.
package video_timing_pkg;

   // 1080p60 raster timing
   localparam int unsigned H_ACTIVE_1080 = 1920;
   localparam int unsigned H_FP_1080     = 88;
   localparam int unsigned H_SYNC_1080   = 44;
   localparam int unsigned H_BP_1080     = 148;
   localparam int unsigned V_ACTIVE_1080 = 1080;
   localparam int unsigned V_FP_1080     = 4;
   localparam int unsigned V_SYNC_1080   = 5;
   localparam int unsigned V_BP_1080     = 36;

   // Counter widths (H_TOTAL up to 4095, V_TOTAL up to 2047)
   localparam int unsigned HW = 12;
   localparam int unsigned VW = 11;

   // Bit positions inside dvh_sync_o and vh_blank_o
   localparam int unsigned DVH_D = 2;
   localparam int unsigned DVH_V = 1;
   localparam int unsigned DVH_H = 0;
   localparam int unsigned VH_V  = 1;
   localparam int unsigned VH_H  = 0;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_SOLID = 2'd3
   } pattern_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

endpackage

// File: rtl/video_timing_gen_pattern.sv
// Combinational test-pattern source; the parent registers its output.
module video_pattern_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = H_ACTIVE_1080,
   parameter logic [23:0] SOLID_RGB = 24'hFF_5A_43
) (
   input  logic [HW-1:0] h_i,
   input  logic          v6_i,
   input  pattern_e      pattern_i,
   output logic [23:0]   rgb_o
);

   // Eight equal-width bars across the active line
   localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

   logic [HW-1:0] bar_s;
   logic [23:0]   bars_rgb_s;

   // Bar index and bar colour lookup
   always_comb begin
      bar_s = h_i / BAR_W;
      case (bar_s)
         12'd0:   bars_rgb_s = 24'hFF_FF_FF;
         12'd1:   bars_rgb_s = 24'hFF_FF_00;
         12'd2:   bars_rgb_s = 24'h00_FF_FF;
         12'd3:   bars_rgb_s = 24'h00_FF_00;
         12'd4:   bars_rgb_s = 24'hFF_00_FF;
         12'd5:   bars_rgb_s = 24'hFF_00_00;
         12'd6:   bars_rgb_s = 24'h00_00_FF;
         default: bars_rgb_s = 24'h00_00_00;
      endcase
   end

   // Pattern multiplexer
   always_comb begin
      case (pattern_i)
         PAT_BARS:  rgb_o = bars_rgb_s;
         PAT_RAMP:  rgb_o = {h_i[7:0], h_i[7:0], h_i[7:0]};
         PAT_CHECK: rgb_o = (h_i[6] ^ v6_i) ? 24'hFF_FF_FF : 24'h00_00_00;
         PAT_SOLID: rgb_o = SOLID_RGB;
         default:   rgb_o = 24'h00_00_00;
      endcase
   end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns; all outputs registered and mutually aligned.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = H_ACTIVE_1080,
   parameter int unsigned H_FP      = H_FP_1080,
   parameter int unsigned H_SYNC    = H_SYNC_1080,
   parameter int unsigned H_BP      = H_BP_1080,
   parameter int unsigned V_ACTIVE  = V_ACTIVE_1080,
   parameter int unsigned V_FP      = V_FP_1080,
   parameter int unsigned V_SYNC    = V_SYNC_1080,
   parameter int unsigned V_BP      = V_BP_1080,
   parameter logic        HS_POL    = 1'b1,
   parameter logic        VS_POL    = 1'b1,
   parameter logic [23:0] SOLID_RGB = 24'hFF_5A_43
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cen_i,
   input  logic          run_i,
   input  logic [1:0]    pattern_sel_i,
   output logic [1:0]    vh_blank_o,
   output logic [2:0]    dvh_sync_o,
   output logic [23:0]   vid_rgb_o,
   output logic [HW-1:0] hcount_o,
   output logic [VW-1:0] vcount_o,
   output logic          frame_start_o,
   output logic [7:0]    frame_cnt_o
);

   localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   state_e        state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   pattern_e      pat_q, pat_eff_s;
   logic          active_s, h_wrap_s, frame_wrap_s, frame_origin_s;
   logic          hblank_s, vblank_s, dsync_s, hsync_s, vsync_s;
   logic [23:0]   pat_rgb_s;

   assign h_wrap_s       = (h_q == H_LAST);
   assign frame_wrap_s   = h_wrap_s && (v_q == V_LAST);
   assign frame_origin_s = (h_q == '0) && (v_q == '0);

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else if (cen_i) begin
         state_q <= state_d;
      end
   end

   // FSM next state; dropping run_i on the very last pixel ends the frame directly
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (run_i) state_d = RUN;
            else       state_d = IDLE;
         end
         RUN: begin
            if (run_i)             state_d = RUN;
            else if (frame_wrap_s) state_d = IDLE;
            else                   state_d = STOP;
         end
         STOP: begin
            if (run_i)             state_d = RUN;
            else if (frame_wrap_s) state_d = IDLE;
            else                   state_d = STOP;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM output: raster is live in RUN and STOP
   always_comb begin
      case (state_q)
         RUN:     active_s = 1'b1;
         STOP:    active_s = 1'b1;
         default: active_s = 1'b0;
      endcase
   end

   // Raster counter next state; parked at the origin while idle
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (active_s) begin
         if (h_wrap_s) begin
            h_d = '0;
            if (v_q == V_LAST) v_d = '0;
            else               v_d = v_q + 11'd1;
         end else begin
            h_d = h_q + 12'd1;
         end
      end else begin
         h_d = '0;
         v_d = '0;
      end
   end

   // Raster counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_q <= '0;
         v_q <= '0;
      end else if (cen_i) begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Pattern shadow: reloaded only at a frame origin so a frame never tears
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pat_q <= PAT_BARS;
      end else if (cen_i && ((active_s && frame_origin_s) || ((state_q == IDLE) && run_i))) begin
         pat_q <= pattern_e'(pattern_sel_i);
      end
   end

   // Timing decode of the current counter state
   always_comb begin
      hblank_s  = (h_q >= H_ACT_L);
      vblank_s  = (v_q >= V_ACT_L);
      dsync_s   = !hblank_s && !vblank_s;
      hsync_s   = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
      vsync_s   = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
      // Pixel (0,0) already uses the pattern being loaded into the shadow
      pat_eff_s = frame_origin_s ? pattern_e'(pattern_sel_i) : pat_q;
   end

   video_pattern_gen #(
      .H_ACTIVE  (H_ACTIVE),
      .SOLID_RGB (SOLID_RGB)
   ) u_pattern (
      .h_i       (h_q),
      .v6_i      (v_q[6]),
      .pattern_i (pat_eff_s),
      .rgb_o     (pat_rgb_s)
   );

   // Output register: one cen behind the counters, idle values outside a frame
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vh_blank_o    <= 2'b11;
         dvh_sync_o    <= {1'b0, ~VS_POL, ~HS_POL};
         vid_rgb_o     <= 24'h00_00_00;
         hcount_o      <= '0;
         vcount_o      <= '0;
         frame_start_o <= 1'b0;
      end else if (cen_i) begin
         if (active_s) begin
            vh_blank_o[VH_V]  <= vblank_s;
            vh_blank_o[VH_H]  <= hblank_s;
            dvh_sync_o[DVH_D] <= dsync_s;
            dvh_sync_o[DVH_V] <= vsync_s;
            dvh_sync_o[DVH_H] <= hsync_s;
            vid_rgb_o         <= dsync_s ? pat_rgb_s : 24'h00_00_00;
            hcount_o          <= h_q;
            vcount_o          <= v_q;
            frame_start_o     <= frame_origin_s;
         end else begin
            vh_blank_o    <= 2'b11;
            dvh_sync_o    <= {1'b0, ~VS_POL, ~HS_POL};
            vid_rgb_o     <= 24'h00_00_00;
            hcount_o      <= '0;
            vcount_o      <= '0;
            frame_start_o <= 1'b0;
         end
      end
   end

   // Completed-frame counter, steps as the last pixel of a frame is emitted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_cnt_o <= 8'd0;
      end else if (cen_i && active_s && frame_wrap_s) begin
         frame_cnt_o <= frame_cnt_o + 8'd1;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: small-raster scoreboard scenarios plus a 1080p spot-check table.
module tb_video_timing_gen;

   typedef struct packed {
      logic [1:0]  vh;
      logic [2:0]  dvh;
      logic [23:0] rgb;
      logic [11:0] hc;
      logic [10:0] vc;
      logic        fs;
      logic [7:0]  fc;
   } exp_t;

   typedef struct packed {
      logic [1:0]  pat;
      int          k;
      logic [23:0] rgb;
      logic        hs;
      logic        hb;
      logic [11:0] hc;
      logic [10:0] vc;
   } vec_t;

   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FRAME = HT * VT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // small-raster DUT signals
   logic rst_s_n, cen_s, run_s;
   logic [1:0] pat_s;
   logic [1:0] s_vh; logic [2:0] s_dvh; logic [23:0] s_rgb;
   logic [11:0] s_hc; logic [10:0] s_vc; logic s_fs; logic [7:0] s_fc;

   // 1080p DUT signals
   logic rst_h_n, cen_h, run_h;
   logic [1:0] pat_h;
   logic [1:0] h_vh; logic [2:0] h_dvh; logic [23:0] h_rgb;
   logic [11:0] h_hc; logic [10:0] h_vc; logic h_fs; logic [7:0] h_fc;

   int total = 0;
   int bad = 0;
   exp_t sb_q[$];

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_small (
      .clk_i(clk), .rst_ni(rst_s_n), .cen_i(cen_s), .run_i(run_s),
      .pattern_sel_i(pat_s), .vh_blank_o(s_vh), .dvh_sync_o(s_dvh),
      .vid_rgb_o(s_rgb), .hcount_o(s_hc), .vcount_o(s_vc),
      .frame_start_o(s_fs), .frame_cnt_o(s_fc)
   );

   video_timing_gen u_hd (
      .clk_i(clk), .rst_ni(rst_h_n), .cen_i(cen_h), .run_i(run_h),
      .pattern_sel_i(pat_h), .vh_blank_o(h_vh), .dvh_sync_o(h_dvh),
      .vid_rgb_o(h_rgb), .hcount_o(h_hc), .vcount_o(h_vc),
      .frame_start_o(h_fs), .frame_cnt_o(h_fc)
   );

   function automatic logic [23:0] bar_col(input int b);
      case (b)
         0: bar_col = 24'hFFFFFF;
         1: bar_col = 24'hFFFF00;
         2: bar_col = 24'h00FFFF;
         3: bar_col = 24'h00FF00;
         4: bar_col = 24'hFF00FF;
         5: bar_col = 24'hFF0000;
         6: bar_col = 24'h0000FF;
         default: bar_col = 24'h000000;
      endcase
   endfunction

   // reference pixel for the small raster H 8/2/2/2, V 4/1/1/1
   function automatic exp_t pix(input int h, input int v, input int pat, input int fc);
      exp_t e;
      logic hb, vb, d, hs, vs;
      logic [7:0] r8;
      hb = (h >= 8);
      vb = (v >= 4);
      d  = !hb && !vb;
      hs = (h >= 10) && (h < 12);
      vs = (v >= 5) && (v < 6);
      r8 = 8'(h);
      e.vh  = {vb, hb};
      e.dvh = {d, vs, hs};
      if (!d)            e.rgb = 24'h000000;
      else if (pat == 0) e.rgb = bar_col(h);
      else if (pat == 1) e.rgb = {r8, r8, r8};
      else if (pat == 2) e.rgb = ((((h / 64) ^ (v / 64)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      else               e.rgb = 24'hFF5A43;
      e.hc = 12'(h);
      e.vc = 11'(v);
      e.fs = (h == 0) && (v == 0);
      e.fc = 8'(fc);
      return e;
   endfunction

   function automatic exp_t idle(input int fc);
      exp_t e;
      e = '0;
      e.vh = 2'b11;
      e.dvh = 3'b000;
      e.fc = 8'(fc);
      return e;
   endfunction

   function automatic exp_t got_small();
      exp_t g;
      g.vh = s_vh; g.dvh = s_dvh; g.rgb = s_rgb; g.hc = s_hc;
      g.vc = s_vc; g.fs = s_fs; g.fc = s_fc;
      return g;
   endfunction

   task automatic cmp(input string name, input exp_t g, input exp_t e);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s got vh=%b dvh=%b rgb=%h h=%0d v=%0d fs=%b fc=%0d want vh=%b dvh=%b rgb=%h h=%0d v=%0d fs=%b fc=%0d",
                  name, g.vh, g.dvh, g.rgb, g.hc, g.vc, g.fs, g.fc,
                  e.vh, e.dvh, e.rgb, e.hc, e.vc, e.fs, e.fc);
      end
   endtask

   // drive one clock of stimulus, queue its expectation, compare after the edge
   task automatic step(input string name, input logic cen, input logic run,
                       input logic [1:0] pat, input exp_t e);
      exp_t x;
      cen_s = cen; run_s = run; pat_s = pat;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         total++; bad++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         x = sb_q.pop_front();
         cmp(name, got_small(), x);
      end
   endtask

   // n consecutive pixels starting at run index k0; frame 0 uses pat_f0, later frames pat_f1
   task automatic run_seq(input string name, input int k0, input int n, input logic run,
                          input logic [1:0] pat_drv, input int pat_f0, input int pat_f1, input int fc0);
      for (int i = 0; i < n; i++) begin
         int k;
         k = k0 + i;
         step(name, 1'b1, run, pat_drv,
              pix(k % HT, (k / HT) % VT, ((k / FRAME) == 0) ? pat_f0 : pat_f1, fc0 + (k + 1) / FRAME));
      end
   endtask

   task automatic reset_small();
      rst_s_n = 1'b0; cen_s = 1'b0; run_s = 1'b0; pat_s = 2'd0;
      #1;
      cmp("reset_vals", got_small(), idle(0));
      rst_s_n = 1'b1;
   endtask

   vec_t vecs[14];
   exp_t e_last;

   initial begin
      rst_s_n = 1'b0; cen_s = 1'b0; run_s = 1'b0; pat_s = 2'd0;
      rst_h_n = 1'b0; cen_h = 1'b0; run_h = 1'b0; pat_h = 2'd0;

      vecs[0]  = '{2'd0, 0,    24'hFFFFFF, 1'b0, 1'b0, 12'd0,    11'd0};
      vecs[1]  = '{2'd0, 240,  24'hFFFF00, 1'b0, 1'b0, 12'd240,  11'd0};
      vecs[2]  = '{2'd0, 480,  24'h00FFFF, 1'b0, 1'b0, 12'd480,  11'd0};
      vecs[3]  = '{2'd0, 1919, 24'h000000, 1'b0, 1'b0, 12'd1919, 11'd0};
      vecs[4]  = '{2'd0, 1920, 24'h000000, 1'b0, 1'b1, 12'd1920, 11'd0};
      vecs[5]  = '{2'd0, 2007, 24'h000000, 1'b0, 1'b1, 12'd2007, 11'd0};
      vecs[6]  = '{2'd0, 2008, 24'h000000, 1'b1, 1'b1, 12'd2008, 11'd0};
      vecs[7]  = '{2'd0, 2051, 24'h000000, 1'b1, 1'b1, 12'd2051, 11'd0};
      vecs[8]  = '{2'd0, 2052, 24'h000000, 1'b0, 1'b1, 12'd2052, 11'd0};
      vecs[9]  = '{2'd1, 300,  24'h2C2C2C, 1'b0, 1'b0, 12'd300,  11'd0};
      vecs[10] = '{2'd2, 63,   24'h000000, 1'b0, 1'b0, 12'd63,   11'd0};
      vecs[11] = '{2'd2, 64,   24'hFFFFFF, 1'b0, 1'b0, 12'd64,   11'd0};
      vecs[12] = '{2'd3, 5,    24'hFF5A43, 1'b0, 1'b0, 12'd5,    11'd0};
      vecs[13] = '{2'd0, 2200, 24'hFFFFFF, 1'b0, 1'b0, 12'd0,    11'd1};

      repeat (3) @(posedge clk);
      #1;

      // continuous run: first output is pixel (0,0) with frame_start, one full frame plus wrap
      reset_small();
      step("s1_start", 1'b1, 1'b1, 2'd0, idle(0));
      run_seq("s1_run", 0, FRAME + 3, 1'b1, 2'd0, 0, 0, 0);

      // cen toggling: same sequence at half rate, outputs frozen while cen is low
      reset_small();
      step("s3_start", 1'b1, 1'b1, 2'd0, idle(0));
      step("s3_hold", 1'b0, 1'b1, 2'd0, idle(0));
      for (int k = 0; k < FRAME + 2; k++) begin
         e_last = pix(k % HT, (k / HT) % VT, 0, (k + 1) / FRAME);
         step("s3_cen1", 1'b1, 1'b1, 2'd0, e_last);
         step("s3_cen0", 1'b0, 1'b1, 2'd0, e_last);
      end

      // run dropped at line 2: frame completes, then idle; re-raise restarts at origin
      reset_small();
      step("s4_start", 1'b1, 1'b1, 2'd0, idle(0));
      run_seq("s4_run", 0, 2 * HT, 1'b1, 2'd0, 0, 0, 0);
      run_seq("s4_drain", 2 * HT, FRAME - 2 * HT, 1'b0, 2'd0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("s4_idle", 1'b1, 1'b0, 2'd0, idle(1));
      step("s4_idle_cen0", 1'b0, 1'b0, 2'd0, idle(1));
      step("s4_restart", 1'b1, 1'b1, 2'd0, idle(1));
      run_seq("s4_rerun", 0, 3, 1'b1, 2'd0, 0, 0, 1);

      // pattern change mid-frame plus a stop/resume: bars finish, next frame is solid
      reset_small();
      step("s5_start", 1'b1, 1'b1, 2'd0, idle(0));
      run_seq("s5_bars", 0, 40, 1'b1, 2'd0, 0, 3, 0);
      run_seq("s5_sel3", 40, 10, 1'b1, 2'd3, 0, 3, 0);
      run_seq("s5_stop", 50, 10, 1'b0, 2'd3, 0, 3, 0);
      run_seq("s5_resume", 60, 60, 1'b1, 2'd3, 0, 3, 0);

      // asynchronous reset mid-line with no clock edge in between
      #2;
      rst_s_n = 1'b0;
      #1;
      cmp("s6_async_rst", got_small(), idle(0));
      rst_s_n = 1'b1;
      cen_s = 1'b0;

      // 1080p spot checks: bar colours, ramp, checker, solid, hsync window, line wrap
      cen_h = 1'b1;
      for (int i = 0; i < 14; i++) begin
         logic [49:0] g, w;
         rst_h_n = 1'b0; run_h = 1'b0; pat_h = vecs[i].pat;
         #1;
         rst_h_n = 1'b1; run_h = 1'b1;
         repeat (vecs[i].k + 2) @(posedge clk);
         #1;
         g = {h_rgb, h_dvh[0], h_vh[0], h_hc, h_vc, h_dvh[2]};
         w = {vecs[i].rgb, vecs[i].hs, vecs[i].hb, vecs[i].hc, vecs[i].vc, !vecs[i].hb};
         total++;
         if (g !== w) begin
            bad++;
            $display("FAIL hd_vec%0d k=%0d got rgb=%h hs=%b hb=%b h=%0d v=%0d d=%b want rgb=%h hs=%b hb=%b h=%0d v=%0d d=%b",
                     i, vecs[i].k, g[49:26], g[25], g[24], g[23:12], g[11:1], g[0],
                     w[49:26], w[25], w[24], w[23:12], w[11:1], w[0]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
